// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags,
// sticky error flags and optional first-word-fall-through read.
module sync_fifo_flags #(
    parameter int data_width = 8,
    parameter int addr_width = 4,
    parameter int af_thresh  = 14,
    parameter int ae_thresh  = 2,
    parameter int fwft       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] data_in,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic                  clr_err,
    output logic [data_width-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int depth = 1 << addr_width;
    localparam logic [addr_width:0]   depth_c = (addr_width+1)'(depth);
    localparam logic [addr_width:0]   af_c    = (addr_width+1)'(af_thresh);
    localparam logic [addr_width:0]   ae_c    = (addr_width+1)'(ae_thresh);
    localparam logic [addr_width:0]   cnt_one = 1;
    localparam logic [addr_width-1:0] ptr_one = 1;

    if (af_thresh < 1 || af_thresh > depth) begin : g_af_bad
        $fatal(1, "sync_fifo_flags: af_thresh out of range");
    end
    if (ae_thresh < 0 || ae_thresh > depth - 1) begin : g_ae_bad
        $fatal(1, "sync_fifo_flags: ae_thresh out of range");
    end

    logic [data_width-1:0] mem [depth];
    logic [addr_width-1:0] wptr;
    logic [addr_width-1:0] rptr;
    logic [addr_width-1:0] rptr_n;
    logic [addr_width:0]   cnt;
    logic                  do_wr;
    logic                  do_rd;

    // Flags come only from the registered count.
    assign count        = cnt;
    assign full         = (cnt == depth_c);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= af_c);
    assign almost_empty = (cnt <= ae_c);

    assign do_wr  = w_en && !full;
    assign do_rd  = r_en && !empty;
    assign rptr_n = do_rd ? rptr + ptr_one : rptr;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + ptr_one;
            end
            rptr <= rptr_n;
            if (do_wr && !do_rd) begin
                cnt <= cnt + cnt_one;
            end else if (do_rd && !do_wr) begin
                cnt <= cnt - cnt_one;
            end
            overflow  <= (w_en && full) || (overflow && !clr_err);
            underflow <= (r_en && empty) || (underflow && !clr_err);
        end
    end

    if (fwft != 0) begin : g_fwft
        logic head_new;
        logic nonempty_n;

        // The word being written is the next head when nothing else is queued.
        assign head_new   = do_wr && (rptr_n == wptr);
        assign nonempty_n = do_wr || (cnt > cnt_one) ||
                            ((cnt == cnt_one) && !do_rd);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_out <= '0;
            end else if (nonempty_n) begin
                data_out <= head_new ? data_in : mem[rptr_n];
            end
        end
    end else begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_out <= '0;
            end else if (do_rd) begin
                data_out <= mem[rptr];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: registered-read and FWFT instances
// driven in lockstep against a queue-based reference model.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       w_en;
    logic       r_en;
    logic       clr_err;

    logic [7:0] d0, d1;
    logic       full0, empty0, af0, ae0, ovf0, unf0;
    logic       full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] count0, count1;

    logic [10:0] st0, st1;
    assign st0 = {full0, empty0, af0, ae0, ovf0, unf0, count0};
    assign st1 = {full1, empty1, af1, ae1, ovf1, unf1, count1};

    localparam logic [10:0] rst_st = {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};

    sync_fifo_flags #(.fwft(0)) u_reg (
        .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en),
        .r_en(r_en), .clr_err(clr_err), .data_out(d0),
        .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(count0),
        .overflow(ovf0), .underflow(unf0)
    );

    sync_fifo_flags #(.fwft(1)) u_fwft (
        .clk(clk), .rst(rst), .data_in(data_in), .w_en(w_en),
        .r_en(r_en), .clr_err(clr_err), .data_out(d1),
        .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1),
        .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    logic [7:0] q[$];
    logic [7:0] m_d0, m_d1;
    logic       m_ovf, m_unf;

    function automatic logic [10:0] exp_st();
        int n;
        n = q.size();
        return {n == 16, n == 0, n >= 14, n <= 2, m_ovf, m_unf, 5'(n)};
    endfunction

    function automatic void model_reset();
        q.delete();
        m_d0  = 8'h00;
        m_d1  = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    task automatic cycle(input logic w, input logic r, input logic c,
                         input logic [7:0] d);
        bit pre_full, pre_empty;
        w_en = w; r_en = r; clr_err = c; data_in = d;
        @(posedge clk);
        pre_full  = (q.size() == 16);
        pre_empty = (q.size() == 0);
        m_ovf = (w && pre_full) || (m_ovf && !c);
        m_unf = (r && pre_empty) || (m_unf && !c);
        if (r && !pre_empty) m_d0 = q.pop_front();
        if (w && !pre_full) q.push_back(d);
        if (q.size() > 0) m_d1 = q[0];
        #1;
        w_en = 1'b0; r_en = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if (st0 !== rst_st) $display("FAIL reset_flags0 got %b want %b", st0, rst_st);
        else n_pass++;
        n_total++;
        if (st1 !== rst_st) $display("FAIL reset_flags1 got %b want %b", st1, rst_st);
        else n_pass++;
        n_total++;
        if (d0 !== 8'h00 || d1 !== 8'h00)
            $display("FAIL reset_dout got %h/%h want 00/00", d0, d1);
        else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        cycle(1, 0, 0, 8'hAB);
        n_total++;
        if (count0 !== 5'd1) $display("FAIL basic_cnt1 got %0d want 1", count0);
        else n_pass++;
        cycle(1, 0, 0, 8'hCD);
        n_total++;
        if (count0 !== 5'd2) $display("FAIL basic_cnt2 got %0d want 2", count0);
        else n_pass++;
        cycle(0, 1, 0, 8'h00);
        n_total++;
        if (d0 !== 8'hAB || count0 !== 5'd1)
            $display("FAIL basic_rd1 got %h/%0d want AB/1", d0, count0);
        else n_pass++;
        cycle(0, 1, 0, 8'h00);
        n_total++;
        if (d0 !== 8'hCD || count0 !== 5'd0 || empty0 !== 1'b1)
            $display("FAIL basic_rd2 got %h/%0d/%b want CD/0/1", d0, count0, empty0);
        else n_pass++;
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0, 0, 8'(i));
            n_total++;
            if (af0 !== (i + 1 >= 14) || full0 !== (i == 15))
                $display("FAIL fill_flags n=%0d got af=%b full=%b", i + 1, af0, full0);
            else n_pass++;
        end
        cycle(1, 0, 0, 8'hFF);
        n_total++;
        if (ovf0 !== 1'b1 || count0 !== 5'd16 || ovf1 !== 1'b1)
            $display("FAIL fill_overflow got ovf=%b cnt=%0d want 1/16", ovf0, count0);
        else n_pass++;
        for (int j = 0; j < 16; j++) begin
            cycle(0, 1, 0, 8'h00);
            n_total++;
            if (d0 !== 8'(j) || ae0 !== (15 - j <= 2) || count0 !== 5'(15 - j))
                $display("FAIL drain_%0d got d=%h ae=%b cnt=%0d want %h/%b/%0d",
                         j, d0, ae0, count0, 8'(j), (15 - j <= 2), 15 - j);
            else n_pass++;
        end
        cycle(0, 0, 1, 8'h00);
        n_total++;
        if (ovf0 !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf0);
        else n_pass++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 8'h20 + 8'(i));
        for (int k = 0; k < 20; k++) begin
            logic [7:0] exp;
            exp = (k < 5) ? 8'h20 + 8'(k) : 8'h30 + 8'(k - 5);
            cycle(1, 1, 0, 8'h30 + 8'(k));
            n_total++;
            if (count0 !== 5'd5 || d0 !== exp)
                $display("FAIL wrap_%0d got cnt=%0d d=%h want 5/%h", k, count0, d0, exp);
            else n_pass++;
        end
    endtask

    task automatic test_underflow();
        while (q.size() > 0) cycle(0, 1, 0, 8'h00);
        cycle(0, 1, 0, 8'h00);
        n_total++;
        if (unf0 !== 1'b1 || d0 !== m_d0)
            $display("FAIL underflow_set got unf=%b d=%h want 1/%h", unf0, d0, m_d0);
        else n_pass++;
        cycle(0, 0, 1, 8'h00);
        n_total++;
        if (unf0 !== 1'b0) $display("FAIL underflow_clr got %b want 0", unf0);
        else n_pass++;
        cycle(0, 1, 1, 8'h00);
        n_total++;
        if (unf0 !== 1'b1 || unf1 !== 1'b1)
            $display("FAIL underflow_wins got %b/%b want 1/1", unf0, unf1);
        else n_pass++;
    endtask

    task automatic test_fwft();
        do_reset();
        cycle(1, 0, 0, 8'h5A);
        n_total++;
        if (empty1 !== 1'b0 || d1 !== 8'h5A)
            $display("FAIL fwft_head got empty=%b d=%h want 0/5A", empty1, d1);
        else n_pass++;
        cycle(0, 1, 0, 8'h00);
        n_total++;
        if (empty1 !== 1'b1 || count1 !== 5'd0 || d1 !== 8'h5A)
            $display("FAIL fwft_pop got empty=%b cnt=%0d d=%h want 1/0/5A",
                     empty1, count1, d1);
        else n_pass++;
        for (int i = 0; i < 7; i++) cycle(1, 0, 0, 8'h60 + 8'(i));
        n_total++;
        if (count1 !== 5'd7 || d1 !== 8'h60)
            $display("FAIL fwft_fill got cnt=%0d d=%h want 7/60", count1, d1);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if (st0 !== rst_st || st1 !== rst_st || d1 !== 8'h00)
            $display("FAIL async_reset got %b/%b d=%h want %b/%b d=00",
                     st0, st1, d1, rst_st, rst_st);
        else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 600; k++) begin
            int wp;
            logic w, r, c;
            wp = (k % 150 < 50) ? 80 : ((k % 150 < 100) ? 20 : 50);
            w = ($urandom_range(0, 99) < wp);
            r = ($urandom_range(0, 99) < 100 - wp);
            c = ($urandom_range(0, 99) < 5);
            cycle(w, r, c, 8'($urandom));
            n_total++;
            if (st0 !== exp_st())
                $display("FAIL rand_st0 k=%0d got %b want %b", k, st0, exp_st());
            else n_pass++;
            n_total++;
            if (st1 !== exp_st())
                $display("FAIL rand_st1 k=%0d got %b want %b", k, st1, exp_st());
            else n_pass++;
            n_total++;
            if (d0 !== m_d0) $display("FAIL rand_d0 k=%0d got %h want %h", k, d0, m_d0);
            else n_pass++;
            n_total++;
            if (d1 !== m_d1) $display("FAIL rand_d1 k=%0d got %h want %h", k, d1, m_d1);
            else n_pass++;
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b0;
        w_en    = 1'b0;
        r_en    = 1'b0;
        clr_err = 1'b0;
        data_in = 8'h00;
        model_reset();
        #1;
        test_reset();
        test_basic();
        test_fill();
        test_wrap();
        test_underflow();
        test_fwft();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
